csa_resolve_round: RTL and testbench

Consumer end of the 48-bit multiplier CSA tree. It accepts the redundant sum/carry pair plus the precomputed sign and exponent, and resolves the pair into a 48-bit product with a multi-cycle chunked carry-propagate adder. It then normalizes and rounds the product (round-to-nearest-even) to a single-precision result and presents it on a valid/ready output.

---
 rtl/fp_mul_pkg.sv | 19 +
 rtl/csa_resolve_round_if.sv | 29 ++
 rtl/csa_resolve_round_chunk_adder.sv | 14 +
 rtl/csa_resolve_round.sv | 145 ++++++++++++++
 tb/tb_csa_resolve_round.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the multiplier back end that resolves the CSA tree output.
package fp_mul_pkg;

   localparam int WIDTH   = 48;
   localparam int CHUNK   = 12;
   localparam int MANT    = 23;
   localparam int EXP_W   = 10;
   localparam int EXP_MAX = 255;
   localparam int NCHUNK  = WIDTH / CHUNK;
   localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_NORM = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/csa_resolve_round_if.sv
// Input and output handshake bundle between the CSA tree and the resolve/round stage.
interface csa_resolve_round_if;
   import fp_mul_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_sum;
   logic [WIDTH-1:0]     in_carry;
   logic                 in_sign;
   logic [EXP_W-1:0]     in_exp;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sign;
   logic [7:0]           out_exp;
   logic [MANT-1:0]      out_mant;
   logic                 out_ovf;
   logic                 out_unf;

   modport master (
      output in_valid, in_sum, in_carry, in_sign, in_exp, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_sum, in_carry, in_sign, in_exp, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant, out_ovf, out_unf
   );

endinterface

// File: rtl/csa_resolve_round_chunk_adder.sv
// One CHUNK-wide slice of the carry-propagate adder, reused every ADD cycle.
module chunk_adder
   import fp_mul_pkg::*;
(
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             c_i,
   output logic [CHUNK-1:0] sum_o,
   output logic             c_o
);

   assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

endmodule

// File: rtl/csa_resolve_round.sv
// Resolves a CSA sum/carry pair chunk by chunk, then normalizes and rounds to single precision.
//
// state | meaning
// IDLE  | waiting for a sum/carry pair, in_ready high
// ADD   | one CHUNK of the product resolved per cycle, low chunk first
// NORM  | normalize, round to nearest even, register result
// DONE  | result presented, held until out_ready
module csa_resolve_round
   import fp_mul_pkg::*;
(
   input  logic                clk,
   input  logic                nreset,
   csa_resolve_round_if.slave  bus
);

   localparam int XW = EXP_W + 2;

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    sum_q, carry_q, p_q;
   logic                cy_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                sign_q;
   logic [EXP_W-1:0]    exp_q;
   logic                out_sign_q, out_ovf_q, out_unf_q;
   logic [7:0]          out_exp_q;
   logic [MANT-1:0]     out_mant_q;

   logic [CHUNK-1:0]    add_s;
   logic                add_c;

   logic [MANT-1:0]     frac;
   logic                guard, sticky, rnd_up;
   logic [MANT:0]       frac_r;
   logic signed [XW-1:0] exp_n, exp_f;

   // Sum and carry are shifted right each cycle so the adder always sees the low chunk.
   chunk_adder u_add (
      .a_i   (sum_q[CHUNK-1:0]),
      .b_i   (carry_q[CHUNK-1:0]),
      .c_i   (cy_q),
      .sum_o (add_s),
      .c_o   (add_c)
   );

   // State register.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; ADD ends when the chunk down-counter reaches zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.in_valid) state_d = ST_ADD;
         ST_ADD:  if (cnt_q == '0)  state_d = ST_NORM;
         ST_NORM: state_d = ST_DONE;
         ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Normalize on the leading bit, round to nearest even; exponent kept wide to catch over/underflow.
   always_comb begin
      exp_n = {{(XW-EXP_W){exp_q[EXP_W-1]}}, exp_q};
      if (p_q[WIDTH-1]) begin
         frac   = p_q[WIDTH-2 -: MANT];
         guard  = p_q[WIDTH-2-MANT];
         sticky = |p_q[WIDTH-3-MANT:0];
         exp_n  = exp_n + XW'(1);
      end else begin
         frac   = p_q[WIDTH-3 -: MANT];
         guard  = p_q[WIDTH-3-MANT];
         sticky = |p_q[WIDTH-4-MANT:0];
      end
      rnd_up = guard & (sticky | frac[0]);
      frac_r = {1'b0, frac} + {{MANT{1'b0}}, rnd_up};
      exp_f  = exp_n + (frac_r[MANT] ? XW'(1) : XW'(0));
   end

   // Datapath: capture on accept, shift-accumulate the product in ADD, register the result in NORM.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sum_q      <= '0;
         carry_q    <= '0;
         p_q        <= '0;
         cy_q       <= 1'b0;
         cnt_q      <= '0;
         sign_q     <= 1'b0;
         exp_q      <= '0;
         out_sign_q <= 1'b0;
         out_exp_q  <= '0;
         out_mant_q <= '0;
         out_ovf_q  <= 1'b0;
         out_unf_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sum_q   <= bus.in_sum;
                  carry_q <= bus.in_carry;
                  sign_q  <= bus.in_sign;
                  exp_q   <= bus.in_exp;
                  cy_q    <= 1'b0;
                  cnt_q   <= CNT_W'(NCHUNK - 1);
               end
            end
            ST_ADD: begin
               sum_q   <= sum_q >> CHUNK;
               carry_q <= carry_q >> CHUNK;
               p_q     <= {add_s, p_q[WIDTH-1:CHUNK]};
               cy_q    <= add_c;
               cnt_q   <= cnt_q - CNT_W'(1);
            end
            ST_NORM: begin
               out_sign_q <= sign_q;
               out_ovf_q  <= 1'b0;
               out_unf_q  <= 1'b0;
               if (exp_f >= XW'(EXP_MAX)) begin
                  out_exp_q  <= 8'hFF;
                  out_mant_q <= '0;
                  out_ovf_q  <= 1'b1;
               end else if (exp_f <= XW'(0)) begin
                  out_exp_q  <= 8'h00;
                  out_mant_q <= '0;
                  out_unf_q  <= 1'b1;
               end else begin
                  out_exp_q  <= exp_f[7:0];
                  out_mant_q <= frac_r[MANT-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_sign  = out_sign_q;
   assign bus.out_exp   = out_exp_q;
   assign bus.out_mant  = out_mant_q;
   assign bus.out_ovf   = out_ovf_q;
   assign bus.out_unf   = out_unf_q;

endmodule

// File: tb/tb_csa_resolve_round.sv
// Self-checking bench for csa_resolve_round: directed cases, randomized model comparison, handshake and reset.
module tb_csa_resolve_round;
   import fp_mul_pkg::*;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   csa_resolve_round_if bus ();

   csa_resolve_round dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [47:0] s;
      logic [47:0] c;
      logic [9:0]  e;
      logic [32:0] x;
   } vec_t;

   // Reference: exact integer sum, normalize by leading bit, round half to even on the discarded remainder.
   function automatic logic [33:0] model(input logic [47:0] s, input logic [47:0] c,
                                         input logic sg, input logic [9:0] e);
      logic [47:0] p, frac, rem, half;
      int sh, ex;
      p    = s + c;
      sh   = p[47] ? 24 : 23;
      frac = (p >> sh) & 48'h7FFFFF;
      rem  = p & ((48'd1 << sh) - 48'd1);
      half = 48'd1 << (sh - 1);
      ex   = int'($signed(e)) + (p[47] ? 1 : 0);
      if (rem > half || (rem == half && frac[0])) frac = frac + 48'd1;
      if (frac == 48'h800000) begin
         frac = 48'd0;
         ex   = ex + 1;
      end
      if (ex >= 255) return {sg, 8'hFF, 23'd0, 2'b10};
      if (ex <= 0)   return {sg, 8'h00, 23'd0, 2'b01};
      return {sg, ex[7:0], frac[22:0], 2'b00};
   endfunction

   function automatic logic [33:0] observed();
      return {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_ovf, bus.out_unf};
   endfunction

   function automatic logic [35:0] out_all();
      return {bus.in_ready, bus.out_valid, bus.out_sign, bus.out_exp, bus.out_mant, bus.out_ovf, bus.out_unf};
   endfunction

   // Drives one transaction, scrambles inputs after the accepting edge, returns latency (-1 on timeout) and the result.
   task automatic do_op(input logic [47:0] s, input logic [47:0] c, input logic sg, input logic [9:0] e,
                        input int rdly, output int lat, output logic [33:0] obs);
      int w;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sum   = s;
      bus.in_carry = c;
      bus.in_sign  = sg;
      bus.in_exp   = e;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sum   = 48'({$urandom, $urandom});
      bus.in_carry = 48'({$urandom, $urandom});
      bus.in_sign  = ~sg;
      bus.in_exp   = 10'($urandom);
      lat = 0;
      while (lat < 50) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid) break;
      end
      if (!bus.out_valid) lat = -1;
      obs = observed();
      repeat (rdly) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      nreset        = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_sum    = '0;
      bus.in_carry  = '0;
      bus.in_sign   = 1'b0;
      bus.in_exp    = '0;
      #12;
      n_checks++;
      if (out_all() !== {1'b1, 35'd0})
         $display("FAIL reset_state got %h want %h", out_all(), {1'b1, 35'd0});
      else n_pass++;
      nreset = 1'b1;
      #10;
      n_checks++;
      if (out_all() !== {1'b1, 35'd0})
         $display("FAIL idle_after_reset got %h want %h", out_all(), {1'b1, 35'd0});
      else n_pass++;
   endtask

   task automatic test_directed();
      vec_t tv[7];
      int lat;
      logic [33:0] obs, exp_v;
      tv[0] = '{48'h400000000000, 48'h000000000000, 10'd127, {8'd127, 23'h000000, 2'b00}};
      tv[1] = '{48'h800000000000, 48'h100000000000, 10'd127, {8'd128, 23'h100000, 2'b00}};
      tv[2] = '{48'h3FFFFFFFFFFF, 48'h000000000001, 10'd100, {8'd100, 23'h000000, 2'b00}};
      tv[3] = '{48'h7FFFFFC00000, 48'h000000000000, 10'd127, {8'd128, 23'h000000, 2'b00}};
      tv[4] = '{48'h400000400000, 48'h000000000000, 10'd127, {8'd127, 23'h000000, 2'b00}};
      tv[5] = '{48'h800000000000, 48'h000000000000, 10'd254, {8'd255, 23'h000000, 2'b10}};
      tv[6] = '{48'h400000000000, 48'h000000000000, 10'd0,   {8'd0,   23'h000000, 2'b01}};
      for (int i = 0; i < 7; i++) begin
         do_op(tv[i].s, tv[i].c, 1'(i), tv[i].e, 0, lat, obs);
         exp_v = {1'(i), tv[i].x};
         n_checks++;
         if (lat !== NCHUNK + 1) $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, NCHUNK + 1);
         else n_pass++;
         n_checks++;
         if (obs !== exp_v) $display("FAIL directed_result[%0d] got %h want %h", i, obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int lat;
      logic [47:0] p, s, c;
      logic [9:0]  e;
      logic        sg;
      logic [33:0] obs, exp_v;
      for (int i = 0; i < 150; i++) begin
         p = 48'({$urandom, $urandom});
         if ($urandom_range(0, 9) < 8 && p[47:46] == 2'b00) p[46] = 1'b1;
         if ($urandom_range(0, 3) == 0) begin
            if (p[47]) p[23:0] = 24'h800000;
            else       p[22:0] = 23'h400000;
         end
         s  = 48'({$urandom, $urandom});
         c  = p - s;
         sg = 1'($urandom);
         if ($urandom_range(0, 9) < 7) e = 10'($urandom_range(1, 253));
         else                          e = 10'($urandom);
         exp_v = model(s, c, sg, e);
         do_op(s, c, sg, e, $urandom_range(0, 3), lat, obs);
         n_checks++;
         if (lat !== NCHUNK + 1) $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, NCHUNK + 1);
         else n_pass++;
         n_checks++;
         if (obs !== exp_v)
            $display("FAIL random_result[%0d] s=%h c=%h e=%h got %h want %h", i, s, c, e, obs, exp_v);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [33:0] snap, exp_v;
      int w;
      exp_v = model(48'h800000000000, 48'h100000000000, 1'b1, 10'd127);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sum   = 48'h800000000000;
      bus.in_carry = 48'h100000000000;
      bus.in_sign  = 1'b1;
      bus.in_exp   = 10'd127;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      w = 0;
      while (!bus.out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      snap = observed();
      n_checks++;
      if (snap !== exp_v) $display("FAIL bp_result got %h want %h", snap, exp_v);
      else n_pass++;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_sum   = 48'({$urandom, $urandom});
         bus.in_exp   = 10'($urandom);
         @(negedge clk);
         n_checks++;
         if ({bus.in_ready, bus.out_valid, observed()} !== {2'b01, exp_v})
            $display("FAIL bp_hold[%0d] got %h want %h", k, {bus.in_ready, bus.out_valid, observed()}, {2'b01, exp_v});
         else n_pass++;
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      n_checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10)
         $display("FAIL bp_release got %b want 10", {bus.in_ready, bus.out_valid});
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int acc[$];
      int cyc, w;
      logic [33:0] exp_v;
      exp_v = model(48'h800000000000, 48'h100000000000, 1'b0, 10'd127);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_sum    = 48'h800000000000;
      bus.in_carry  = 48'h100000000000;
      bus.in_sign   = 1'b0;
      bus.in_exp    = 10'd127;
      bus.out_ready = 1'b1;
      cyc = 0;
      for (int k = 0; k < 30; k++) begin
         if (bus.in_ready) acc.push_back(cyc);
         @(negedge clk);
         cyc++;
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (acc.size() < 3) $display("FAIL b2b_accepts got %0d want >=3", acc.size());
      else n_pass++;
      for (int k = 1; k < acc.size() && k < 4; k++) begin
         n_checks++;
         if (acc[k] - acc[k-1] !== NCHUNK + 3)
            $display("FAIL b2b_interval[%0d] got %0d want %0d", k, acc[k] - acc[k-1], NCHUNK + 3);
         else n_pass++;
      end
      w = 0;
      while (!bus.out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (observed() !== exp_v) $display("FAIL b2b_result got %h want %h", observed(), exp_v);
      else n_pass++;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [33:0] obs;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sum   = 48'h800000000000;
      bus.in_carry = 48'h100000000000;
      bus.in_sign  = 1'b1;
      bus.in_exp   = 10'd200;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      nreset = 1'b0;
      #1;
      n_checks++;
      if (out_all() !== {1'b1, 35'd0})
         $display("FAIL midreset_state got %h want %h", out_all(), {1'b1, 35'd0});
      else n_pass++;
      @(negedge clk);
      nreset = 1'b1;
      repeat (6) begin
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b0) $display("FAIL midreset_dropped got %b want 0", bus.out_valid);
         else n_pass++;
      end
      do_op(48'h400000000000, 48'h0, 1'b0, 10'd127, 1, lat, obs);
      n_checks++;
      if (lat !== NCHUNK + 1) $display("FAIL midreset_latency got %0d want %0d", lat, NCHUNK + 1);
      else n_pass++;
      n_checks++;
      if (obs !== {1'b0, 8'd127, 23'd0, 2'b00})
         $display("FAIL midreset_result got %h want %h", obs, {1'b0, 8'd127, 23'd0, 2'b00});
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
